// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the data-memory arbiter: FSM states and requester selects.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    S_CPU   = 2'd0,
    S_EXT   = 2'd1,
    S_LOCK  = 2'd2,
    S_FORCE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_CPU  = 2'd1,
    SEL_EXT  = 2'd2
  } sel_t;

  // Counter width able to hold 0..max_wait-1 (max_wait >= 2).
  function automatic int wait_cnt_width(input int max_wait);
    return (max_wait > 2) ? $clog2(max_wait) : 1;
  endfunction

endpackage

// File: rtl/dmem_arb_starve_cnt.sv
// Consecutive CPU stall counter; trip fires on the MAX_WAIT-th stall cycle in a row.
module dmem_arb_starve_cnt
  import dmem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic stall,
  output logic trip
);

  localparam int CW = wait_cnt_width(MAX_WAIT);

  logic [CW-1:0] wcnt_reg;

  assign trip = stall && (wcnt_reg == CW'(MAX_WAIT - 1));

  always_ff @(posedge clk) begin
    if (reset || trip || !stall) begin
      wcnt_reg <= '0;
    end else begin
      wcnt_reg <= wcnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates one data-memory port between the CPU memory stage and an external requester.
// Optional starvation guard (wait counter + S_FORCE) enabled by defining DMEM_ARB_STARVE_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic          ext_lock,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
  output logic          ext_gnt,
  output logic [DW-1:0] ext_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  state_t state_reg;
  state_t state_next;
  sel_t   sel;
  logic   cpu_gnt;

  // Grant is purely combinational so an access completes in the cycle it is presented.
  always_comb begin
    sel = SEL_NONE;
    if (!reset) begin
      case (state_reg)
        S_EXT: begin
          if (cpu_req)      sel = SEL_CPU;
          else if (ext_req) sel = SEL_EXT;
        end
`ifdef DMEM_ARB_STARVE_EN
        S_FORCE: begin
          if (cpu_req) sel = SEL_CPU;
        end
`endif
        default: begin
          if (ext_req)      sel = SEL_EXT;
          else if (cpu_req) sel = SEL_CPU;
        end
      endcase
    end
  end

  assign cpu_gnt   = (sel == SEL_CPU);
  assign ext_gnt   = (sel == SEL_EXT);
  assign cpu_stall = cpu_req & ~cpu_gnt & ~reset;
  assign cpu_rdata = mem_rdata;
  assign ext_rdata = mem_rdata;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (sel)
      SEL_CPU: begin
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
      SEL_EXT: begin
        mem_we    = ext_we;
        mem_addr  = ext_addr;
        mem_wdata = ext_wdata;
      end
      default: ;
    endcase
  end

`ifdef DMEM_ARB_STARVE_EN
  logic trip;

  dmem_arb_starve_cnt #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_cnt (
    .clk   (clk),
    .reset (reset),
    .stall (cpu_stall),
    .trip  (trip)
  );
`endif

  always_comb begin
    state_next = S_CPU;
`ifdef DMEM_ARB_STARVE_EN
    if (trip) begin
      state_next = S_FORCE;
    end else
`endif
    if (ext_gnt) begin
      state_next = ext_lock ? S_LOCK : S_EXT;
    end
`ifdef DMEM_ARB_STARVE_EN
    // Leaving a forced CPU beat hands a still-locked burst straight back to ext.
    else if (cpu_gnt && (state_reg == S_FORCE) && ext_req && ext_lock) begin
      state_next = S_LOCK;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_CPU;
    end else begin
      state_reg <= state_next;
    end
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the CPU's single data-memory port between the pipeline's memory stage and an external requester (program loader / debug port). Each cycle it grants at most one access, steering address, write data and write enable to memory. It stalls the CPU's memory stage when the CPU loses arbitration. It sits between `riscv_cpu`'s `MemWrite`/`Mem_WrAddr`/`Mem_WrData`/`ReadData` port and the data memory.

## Interface
Parameters:
- `AW`, 32: address width.
- `DW`, 32: data width.
- `MAX_WAIT`, 8: maximum consecutive CPU stall cycles under an external lock. Legal range is ≥2.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `cpu_req` in 1: CPU memory-stage access (load or store) valid.
- `cpu_we` in 1: CPU store.
- `cpu_addr` in AW: CPU byte address.
- `cpu_wdata` in DW: CPU store data.
- `cpu_rdata` out DW: load data to CPU.
- `cpu_stall` out 1: hold CPU memory stage this cycle.
- `ext_req` in 1: external access valid.
- `ext_we` in 1: external write.
- `ext_lock` in 1: external requests burst ownership.
- `ext_addr` in AW: external address.
- `ext_wdata` in DW: external write data.
- `ext_gnt` out 1: external access performed this cycle.
- `ext_rdata` out DW: read data to external.
- `mem_we` out 1: memory write enable.
- `mem_addr` out AW: memory address.
- `mem_wdata` out DW: memory write data.
- `mem_rdata` in DW: memory read data, combinational from `mem_addr`.

## Operation
- The grant is combinational from the current state and requests. The state and counter update on `clk`.
- At most one of `cpu_gnt` (internal) and `ext_gnt` is high in any cycle.
- `cpu_stall = cpu_req & ~cpu_gnt`.
- Data paths:
  - `cpu_rdata = ext_rdata = mem_rdata`.
  - `mem_addr`/`mem_wdata` select the granted requester. They are 0 when there is no grant.
  - `mem_we` equals the granted requester's `we`, and is 0 when there is no grant.
- Grant rules by state:
  - S_CPU (idle, or CPU served last): grant ext if `ext_req`, else CPU if `cpu_req`.
  - S_EXT (ext served last, unlocked): grant CPU if `cpu_req`, else ext if `ext_req`. Strict alternation under contention.
  - S_LOCK: grant ext if `ext_req`, else CPU if `cpu_req`.
  - S_FORCE: grant CPU if `cpu_req`. `ext_gnt` is 0 regardless of `ext_req`.
- Next state, in priority order:
  1. Starvation trip (see below) → S_FORCE.
  2. Ext granted → S_LOCK if `ext_lock`, else S_EXT.
  3. CPU granted, leaving S_FORCE → S_LOCK if `ext_req & ext_lock`, else S_CPU.
  4. CPU granted otherwise → S_CPU.
  5. No grant → S_CPU. The lock is lost when `ext_req` drops.
- Wait counter `wcnt` (0..MAX_WAIT-1):
  - Increments in each cycle where `cpu_stall`=1.
  - Clears on a CPU grant or when `cpu_req`=0.
  - Trip: `cpu_stall`=1 and `wcnt`==MAX_WAIT-1. This sets the next state to S_FORCE and clears `wcnt`.
- Result: the CPU never sees more than MAX_WAIT consecutive stall cycles.
- Reset while high:
  - `ext_gnt`=0, `mem_we`=0, `cpu_stall`=0, `mem_addr`/`mem_wdata`=0.
  - State ← S_CPU, `wcnt` ← 0.
  - Any in-flight lock is dropped.
  - The first cycle after reset deasserts behaves as S_CPU.

## Timing
- Zero-cycle grant latency: a granted access completes in the cycle it is presented. Load data is valid in that same cycle.
- A stalled requester must hold `req`/`we`/`addr`/`wdata` stable until granted. The CPU does this via `cpu_stall`. The external side holds until `ext_gnt`.
- Grant outputs are combinational in `cpu_req`/`ext_req`/`ext_lock`. There is no registered path from request to `mem_*`.
- Simultaneous first requests out of reset go to ext, with CPU served next cycle, unless ext is locked.
- Dropping `ext_lock` on the last granted locked beat returns the block to S_EXT, so the CPU wins the next contention.

## Configuration
- `DMEM_ARB_STARVE_EN` defined: the wait counter and S_FORCE are implemented as above.
- `DMEM_ARB_STARVE_EN` undefined:
  - No counter and no S_FORCE.
  - A locked external requester can stall the CPU indefinitely.
  - `MAX_WAIT` is ignored.
  - All other behaviour is identical.

## Structure
- Package `dmem_arb_pkg`:
  - State encodings S_CPU=2'd0, S_EXT=2'd1, S_LOCK=2'd2, S_FORCE=2'd3.
  - Requester select constants SEL_NONE, SEL_CPU, SEL_EXT.
- Optional sub-module `dmem_arb_starve_cnt`:
  - Contains the wait counter and the trip compare.
  - Parameterised by MAX_WAIT.
  - Instantiated only under `DMEM_ARB_STARVE_EN`.
- Top `dmem_arbiter` holds the state register, the grant logic and the data muxes.

## Test plan
- Reset: assert `reset` with `cpu_req`=`ext_req`=1 → `mem_we`=0, `ext_gnt`=0, `cpu_stall`=0. The first cycle after release grants ext.
- CPU only: CPU store `cpu_addr`=0x100, `cpu_wdata`=0xDEADBEEF, then a load of 0x100 → `mem_we`=1 in cycle 1. The load returns 0xDEADBEEF the same cycle, and `cpu_stall`=0 in both cycles.
- Contention alternation: `cpu_req`=`ext_req`=1 held for 4 cycles, unlocked → grants ext, CPU, ext, CPU. `cpu_stall` pattern is 1,0,1,0.
- Locked burst: `ext_lock`=1, `ext_req`=1 for 4 beats, `cpu_req`=1 → 4 ext grants with `cpu_stall`=1 throughout. Dropping `ext_lock` on beat 4 gives the CPU the next cycle.
- Starvation (macro on, MAX_WAIT=8): lock held with continuous ext and CPU requests → CPU stalls exactly 8 cycles, is granted in cycle 9 with `ext_gnt`=0, and ext resumes in cycle 10. Macro off: CPU is still stalled at cycle 20.
- Mid-lock reset: assert `reset` during beat 2 of a locked burst → the lock is lost. After release, CPU-only traffic is granted with no stall.
